// File: rtl/mlp_pkg.sv
// Shared register map, CTRL bit positions and sequencer states for the mlp host side.
package mlp_pkg;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_INPUT  = 2'd1;
    localparam logic [1:0] REG_WEIGHT = 2'd2;
    localparam logic [1:0] REG_OUTPUT = 2'd3;

    localparam int CTRL_RUN_BIT       = 0;
    localparam int CTRL_DONE_BIT      = 1;
    localparam int CTRL_LAYER_SEL_BIT = 3;

    typedef enum logic [3:0] {
        S_IDLE, S_CLR, S_LD_IN, S_LD_HID, S_SEL_OUT, S_LD_OUT,
        S_RUN, S_POLL, S_RD, S_DONE, S_ERR
    } seq_state_t;

endpackage

// File: rtl/mlp_bus_writer.sv
// Two-cycle register write engine: one strobe cycle, one gap cycle per accepted request.
module mlp_bus_writer #(
    parameter int WGT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req,
    input  logic [1:0]           req_addr,
    input  logic [31:0]          req_data,
    input  logic                 req_rom,
    input  logic [WGT_WIDTH-1:0] rom_data,
    output logic                 ack,
    output logic                 write_en,
    output logic [1:0]           addr,
    output logic [31:0]          writedata
);

    logic [31:0] data_q;
    logic        rom_q;

    // A request is taken in any cycle that is not a strobe cycle, so back-to-back
    // requests land on a strict strobe/gap rhythm.
    assign ack = req && !write_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            write_en <= 1'b0;
            addr     <= 2'd0;
            data_q   <= 32'd0;
            rom_q    <= 1'b0;
        end else begin
            write_en <= ack;
            if (ack) begin
                addr   <= req_addr;
                data_q <= req_data;
                rom_q  <= req_rom;
            end
        end
    end

    // Weight words arrive from the synchronous ROM during the strobe cycle itself.
    assign writedata = rom_q ? 32'($signed(rom_data)) : data_q;

endmodule

// File: rtl/mlp_host_sequencer.sv
// Standalone host controller: loads inputs and weights into the mlp, runs it, polls DONE, reads the result.
module mlp_host_sequencer
    import mlp_pkg::*;
#(
    parameter int N_INPUTS     = 2,
    parameter int N_HIDDEN     = 4,
    parameter int N_OUTPUT     = 1,
    parameter int IN_WIDTH     = 16,
    parameter int WGT_WIDTH    = 16,
    parameter int OUT_WIDTH    = 16,
    parameter int POLL_TIMEOUT = 1024,
    parameter int ROM_AW       = $clog2(N_HIDDEN*(N_INPUTS+1)+N_OUTPUT*(N_HIDDEN+1))
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [N_INPUTS*IN_WIDTH-1:0] in_vec,
    output logic [ROM_AW-1:0]            rom_addr,
    input  logic [WGT_WIDTH-1:0]         rom_data,
    output logic                         write_en,
    output logic [1:0]                   addr,
    output logic [31:0]                  writedata,
    input  logic [31:0]                  readdata,
    output logic                         busy,
    output logic [OUT_WIDTH-1:0]         result,
    output logic                         result_valid,
    output logic                         timeout_err
);

    localparam int N_HID_W = N_HIDDEN*(N_INPUTS+1);
    localparam int N_OUT_W = N_HIDDEN+1;
    localparam int WC_MAX0 = (N_INPUTS > N_HID_W) ? N_INPUTS : N_HID_W;
    localparam int WC_MAX  = (WC_MAX0 > 3) ? WC_MAX0 : 3;
    localparam int WC_W    = $clog2(WC_MAX+1);
    localparam int PC_W    = $clog2(POLL_TIMEOUT+1);

    if (N_OUTPUT != 1) begin : g_chk_out
        $error("mlp_host_sequencer: read phase supports N_OUTPUT == 1 only");
    end

    seq_state_t                   state, state_nx;
    logic [WC_W-1:0]              wcnt;
    logic [PC_W-1:0]              pcnt;
    logic [N_INPUTS*IN_WIDTH-1:0] in_lat;
    logic                         req, req_rom, ack, accept;
    logic [1:0]                   req_addr;
    logic [31:0]                  req_data;
    logic                         unused_readdata;

    assign unused_readdata = &{1'b0, readdata};
    assign accept = (state == S_IDLE) && start;

    mlp_bus_writer #(.WGT_WIDTH(WGT_WIDTH)) u_wr (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_addr (req_addr),
        .req_data (req_data),
        .req_rom  (req_rom),
        .rom_data (rom_data),
        .ack      (ack),
        .write_en (write_en),
        .addr     (addr),
        .writedata(writedata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        req      = 1'b0;
        req_rom  = 1'b0;
        req_addr = REG_CTRL;
        req_data = 32'd0;
        case (state)
            S_IDLE:    if (start) state_nx = S_CLR;
            S_CLR: begin
                req = 1'b1;
                if (ack) state_nx = S_LD_IN;
            end
            S_LD_IN: begin
                req      = 1'b1;
                req_addr = REG_INPUT;
                req_data = 32'($signed(in_lat[int'(wcnt)*IN_WIDTH +: IN_WIDTH]));
                if (ack && wcnt == WC_W'(N_INPUTS-1)) state_nx = S_LD_HID;
            end
            S_LD_HID: begin
                req      = 1'b1;
                req_rom  = 1'b1;
                req_addr = REG_WEIGHT;
                if (ack && wcnt == WC_W'(N_HID_W-1)) state_nx = S_SEL_OUT;
            end
            S_SEL_OUT: begin
                req      = 1'b1;
                req_data = 32'd1 << CTRL_LAYER_SEL_BIT;
                if (ack) state_nx = S_LD_OUT;
            end
            S_LD_OUT: begin
                req      = 1'b1;
                req_rom  = 1'b1;
                req_addr = REG_WEIGHT;
                if (ack && wcnt == WC_W'(N_OUT_W-1)) state_nx = S_RUN;
            end
            S_RUN: begin
                req      = 1'b1;
                req_data = 32'd1 << CTRL_RUN_BIT;
                if (ack) state_nx = S_POLL;
            end
            S_POLL: begin
                // First POLL cycle is the RUN strobe itself, so readdata is stale there.
                if (pcnt != '0 && readdata[CTRL_DONE_BIT]) state_nx = S_RD;
                else if (pcnt == PC_W'(POLL_TIMEOUT))     state_nx = S_ERR;
            end
            S_RD: begin
                req      = (wcnt == '0);
                req_addr = REG_OUTPUT;
                if (wcnt == WC_W'(2)) state_nx = S_DONE;
            end
            S_DONE:  state_nx = S_IDLE;
            S_ERR:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt         <= '0;
            pcnt         <= '0;
            in_lat       <= '0;
            rom_addr     <= '0;
            busy         <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            // RD reuses the word counter to time the read strobe -> registered readdata.
            if (state_nx != state)                       wcnt <= '0;
            else if (ack || (state == S_RD && wcnt != '0)) wcnt <= wcnt + WC_W'(1);
            pcnt <= (state == S_POLL) ? pcnt + PC_W'(1) : '0;
            if (accept) begin
                in_lat      <= in_vec;
                rom_addr    <= '0;
                busy        <= 1'b1;
                timeout_err <= 1'b0;
            end else if (ack && req_rom) begin
                rom_addr <= rom_addr + ROM_AW'(1);
            end
            if (state == S_DONE || state == S_ERR) busy <= 1'b0;
            if (state == S_POLL && state_nx == S_ERR) timeout_err <= 1'b1;
            if (state == S_RD && wcnt == WC_W'(2)) begin
                result       <= readdata[OUT_WIDTH-1:0];
                result_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mlp_host_sequencer.sv
// Directed bench: behavioural mlp stub + weight ROM around the sequencer, bus trace and result checks.
module tb_mlp_host_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] in_vec;
    logic [4:0]  rom_addr;
    logic [15:0] rom_data;
    logic        write_en;
    logic [1:0]  addr;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        busy;
    logic [15:0] result;
    logic        result_valid;
    logic        timeout_err;

    always #5 clk = ~clk;

    mlp_host_sequencer #(.POLL_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .start(start), .in_vec(in_vec),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .write_en(write_en), .addr(addr), .writedata(writedata), .readdata(readdata),
        .busy(busy), .result(result), .result_valid(result_valid), .timeout_err(timeout_err)
    );

    // weight ROM, synchronous read
    logic [15:0] rom [0:31];
    always @(posedge clk) rom_data <= rom[rom_addr];

    // mlp stub: result = low bits of the sum of all input/weight words it received
    logic        stub_dead = 1'b0;
    logic        done = 1'b0;
    logic [3:0]  dcnt = 4'd0;
    logic [31:0] acc = 32'd0;
    always @(posedge clk) begin
        if (write_en) begin
            case (addr)
                2'd0: begin
                    done <= 1'b0;
                    dcnt <= writedata[0] ? 4'd6 : 4'd0;
                    if (writedata == 32'd0) acc <= 32'd0;
                end
                2'd1, 2'd2: acc <= acc + writedata;
                default: ;
            endcase
        end else if (dcnt != 4'd0) begin
            dcnt <= dcnt - 4'd1;
            if (dcnt == 4'd1 && !stub_dead) done <= 1'b1;
        end
        readdata <= (addr == 2'd0) ? {30'd0, done, 1'b0} : ((addr == 2'd3) ? acc : 32'd0);
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0, acc_cyc = 0, run_cyc = 0, done_cyc = 0, rv_cyc = 0, to_cyc = 0, rv_n = 0;
    logic [1:0]  wa[$], ea[$];
    logic [31:0] wd[$], ed[$];
    logic [15:0] exp_res, prev_res;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
        cyc++;
        if (write_en) begin
            wa.push_back(addr);
            wd.push_back(writedata);
            if (addr == 2'd0 && writedata == 32'd1) run_cyc = cyc;
        end
        if (readdata[1] && run_cyc != 0 && cyc > run_cyc && done_cyc == 0) done_cyc = cyc;
        if (result_valid) begin rv_n++; rv_cyc = cyc; end
        if (timeout_err && to_cyc == 0) to_cyc = cyc;
    endtask

    task automatic push(input logic [1:0] a, input logic [31:0] d);
        ea.push_back(a);
        ed.push_back(d);
    endtask

    task automatic build_exp(input logic [15:0] i0, input logic [15:0] i1);
        logic [31:0] s;
        ea.delete(); ed.delete();
        push(2'd0, 32'd0);
        push(2'd1, 32'($signed(i0)));
        push(2'd1, 32'($signed(i1)));
        for (int i = 0; i < 12; i++) push(2'd2, 32'($signed(rom[i])));
        push(2'd0, 32'd8);
        for (int i = 12; i < 17; i++) push(2'd2, 32'($signed(rom[i])));
        push(2'd0, 32'd1);
        push(2'd3, 32'd0);
        s = 32'd0;
        for (int i = 0; i < ed.size(); i++) if (ea[i] == 2'd1 || ea[i] == 2'd2) s += ed[i];
        exp_res = s[15:0];
    endtask

    task automatic clear_log();
        wa.delete(); wd.delete();
        run_cyc = 0; done_cyc = 0; rv_n = 0; to_cyc = 0; rv_cyc = 0;
    endtask

    task automatic do_run(input logic [15:0] i0, input logic [15:0] i1, input bit hold);
        build_exp(i0, i1);
        clear_log();
        in_vec  = {i1, i0};
        start   = 1'b1;
        acc_cyc = cyc;
        tick();
        if (!hold) start = 1'b0;
        in_vec = 32'hDEAD_BEEF;      // post-acceptance change must not leak into the run
        for (int k = 0; k < 400 && busy; k++) tick();
        start = 1'b0;
        check("busy_released", {31'd0, busy}, 32'd0);
    endtask

    task automatic check_trace(input string tag);
        check({tag, "_nwr"}, wa.size(), ea.size());
        for (int i = 0; i < ea.size() && i < wa.size(); i++) begin
            check($sformatf("%s_a%0d", tag, i), {30'd0, wa[i]}, {30'd0, ea[i]});
            check($sformatf("%s_d%0d", tag, i), wd[i], ed[i]);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rom[i] = 16'(i*37 - 300);
        rom[5] = 16'h8000;
        rst = 1'b1; start = 1'b1; in_vec = 32'd0;
        tick(); tick();
        // start held during reset must not be taken
        check("rst_write_en",  {31'd0, write_en}, 32'd0);
        check("rst_addr",      {30'd0, addr}, 32'd0);
        check("rst_writedata", writedata, 32'd0);
        check("rst_rom_addr",  {27'd0, rom_addr}, 32'd0);
        check("rst_busy",      {31'd0, busy}, 32'd0);
        check("rst_result",    {16'd0, result}, 32'd0);
        check("rst_rv",        {31'd0, result_valid}, 32'd0);
        check("rst_to",        {31'd0, timeout_err}, 32'd0);
        start = 1'b0;
        rst = 1'b0;
        tick(); tick();

        // 1: basic run with negative input
        do_run(16'hFF00, 16'h0200, 1'b0);
        check_trace("t1");
        check("t1_result", {16'd0, result}, {16'd0, exp_res});
        check("t1_rv_pulses", rv_n, 1);
        // RUN request issued 43 cycles after acceptance; its strobe appears one cycle later
        check("t1_run_lat", run_cyc - acc_cyc, 44);
        check("t1_done_to_rv", rv_cyc - done_cyc, 4);
        check("t1_w0x8000", wd.size() > 8 ? wd[8] : 32'hX, 32'hFFFF_8000);

        // 2: back-to-back runs
        do_run(16'h0011, 16'hFFF0, 1'b0);
        check_trace("t2a");
        check("t2a_result", {16'd0, result}, {16'd0, exp_res});
        do_run(16'h7FFF, 16'h8000, 1'b0);
        check_trace("t2b");
        check("t2b_result", {16'd0, result}, {16'd0, exp_res});

        // 3: start held high throughout -> exactly one run
        do_run(16'h0003, 16'h0004, 1'b1);
        for (int k = 0; k < 5; k++) tick();
        check("t3_nwr", wa.size(), 23);
        check("t3_rv_pulses", rv_n, 1);
        check("t3_result", {16'd0, result}, {16'd0, exp_res});

        // 4: DONE never arrives
        prev_res  = result;
        stub_dead = 1'b1;
        do_run(16'h0001, 16'h0002, 1'b0);
        check("t4_timeout_err", {31'd0, timeout_err}, 32'd1);
        check("t4_rv_pulses", rv_n, 0);
        check("t4_poll_len_ok", {31'd0, (to_cyc - run_cyc) >= 17 && (to_cyc - run_cyc) <= 18}, 32'd1);
        check("t4_result_held", {16'd0, result}, {16'd0, prev_res});
        stub_dead = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t4_to_cleared", {31'd0, timeout_err}, 32'd0);
        for (int k = 0; k < 400 && busy; k++) tick();
        check("t4_recover_busy", {31'd0, busy}, 32'd0);

        // 5: reset in the middle of the hidden-weight load
        clear_log();
        in_vec = {16'h0005, 16'hFFFB};
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 100 && wa.size() < 8; k++) tick();
        rst = 1'b1;
        #1;
        check("t5_write_en", {31'd0, write_en}, 32'd0);
        check("t5_busy",     {31'd0, busy}, 32'd0);
        check("t5_rom_addr", {27'd0, rom_addr}, 32'd0);
        check("t5_wdata",    writedata, 32'd0);
        check("t5_addr",     {30'd0, addr}, 32'd0);
        tick(); tick();
        check("t5_no_more_wr", wa.size(), 8);
        rst = 1'b0;
        tick();
        do_run(16'hFFFB, 16'h0005, 1'b0);
        check_trace("t5");
        check("t5_result", {16'd0, result}, {16'd0, exp_res});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
